// File: rtl/vector_sub_10_serial.sv
// Serial 10-element vector subtractor: D[k] = S[k] - B[k], one element per enabled cycle
// through a single shared subtractor, with early/final completion strobes.
module vector_sub_10_serial #(
  parameter int IN_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inReady,
  input  logic signed [IN_WIDTH:0]   S0,
  input  logic signed [IN_WIDTH:0]   S1,
  input  logic signed [IN_WIDTH:0]   S2,
  input  logic signed [IN_WIDTH:0]   S3,
  input  logic signed [IN_WIDTH:0]   S4,
  input  logic signed [IN_WIDTH:0]   S5,
  input  logic signed [IN_WIDTH:0]   S6,
  input  logic signed [IN_WIDTH:0]   S7,
  input  logic signed [IN_WIDTH:0]   S8,
  input  logic signed [IN_WIDTH:0]   S9,
  input  logic signed [IN_WIDTH-1:0] B0,
  input  logic signed [IN_WIDTH-1:0] B1,
  input  logic signed [IN_WIDTH-1:0] B2,
  input  logic signed [IN_WIDTH-1:0] B3,
  input  logic signed [IN_WIDTH-1:0] B4,
  input  logic signed [IN_WIDTH-1:0] B5,
  input  logic signed [IN_WIDTH-1:0] B6,
  input  logic signed [IN_WIDTH-1:0] B7,
  input  logic signed [IN_WIDTH-1:0] B8,
  input  logic signed [IN_WIDTH-1:0] B9,
  output logic signed [IN_WIDTH+1:0] D0,
  output logic signed [IN_WIDTH+1:0] D1,
  output logic signed [IN_WIDTH+1:0] D2,
  output logic signed [IN_WIDTH+1:0] D3,
  output logic signed [IN_WIDTH+1:0] D4,
  output logic signed [IN_WIDTH+1:0] D5,
  output logic signed [IN_WIDTH+1:0] D6,
  output logic signed [IN_WIDTH+1:0] D7,
  output logic signed [IN_WIDTH+1:0] D8,
  output logic signed [IN_WIDTH+1:0] D9,
  output logic                       outReady,
  output logic                       earlyOutReady,
  output logic                       busy
);

  localparam int NELEM = 10;
  localparam int DW    = IN_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     r_state, w_next;
  logic [3:0]                 r_idx;
  logic signed [IN_WIDTH:0]   w_s [NELEM];
  logic signed [IN_WIDTH:0]   r_s [NELEM];
  logic signed [IN_WIDTH-1:0] w_b [NELEM];
  logic signed [IN_WIDTH-1:0] r_b [NELEM];
  logic signed [DW-1:0]       r_d [NELEM];
  logic signed [DW-1:0]       w_s_ext, w_b_ext, w_diff;
  logic                       w_capture, w_step;
  logic                       r_out, r_early;

  assign w_s[0] = S0;  assign w_s[1] = S1;  assign w_s[2] = S2;  assign w_s[3] = S3;
  assign w_s[4] = S4;  assign w_s[5] = S5;  assign w_s[6] = S6;  assign w_s[7] = S7;
  assign w_s[8] = S8;  assign w_s[9] = S9;
  assign w_b[0] = B0;  assign w_b[1] = B1;  assign w_b[2] = B2;  assign w_b[3] = B3;
  assign w_b[4] = B4;  assign w_b[5] = B5;  assign w_b[6] = B6;  assign w_b[7] = B7;
  assign w_b[8] = B8;  assign w_b[9] = B9;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (inReady) w_next = RUN;
      RUN:     if (r_idx == 4'd9) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       r_state <= IDLE;
    else if (enable) r_state <= w_next;
  end

  assign w_capture = (r_state == IDLE) && inReady;
  assign w_step    = (r_state == RUN);

  // Operands widened to IN_WIDTH+2 so the difference can never overflow.
  assign w_s_ext = {r_s[r_idx][IN_WIDTH], r_s[r_idx]};
  assign w_b_ext = {{2{r_b[r_idx][IN_WIDTH-1]}}, r_b[r_idx]};
  assign w_diff  = w_s_ext - w_b_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_out   <= 1'b0;
      r_early <= 1'b0;
      for (int unsigned i = 0; i < NELEM; i++) begin
        r_s[i] <= '0;
        r_b[i] <= '0;
        r_d[i] <= '0;
      end
    end else if (enable) begin
      r_early <= w_step && (r_idx == 4'd8);
      r_out   <= w_step && (r_idx == 4'd9);
      if (w_capture) begin
        r_s   <= w_s;
        r_b   <= w_b;
        r_idx <= '0;
      end
      if (w_step) begin
        r_d[r_idx] <= w_diff;
        if (r_idx != 4'd9) r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign outReady      = r_out;
  assign earlyOutReady = r_early;

  assign D0 = r_d[0];  assign D1 = r_d[1];  assign D2 = r_d[2];  assign D3 = r_d[3];
  assign D4 = r_d[4];  assign D5 = r_d[5];  assign D6 = r_d[6];  assign D7 = r_d[7];
  assign D8 = r_d[8];  assign D9 = r_d[9];

endmodule

// File: tb/tb_vector_sub_10_serial.sv
// Self-checking bench for vector_sub_10_serial: vector table plus multi-cycle corner sequences,
// with expected difference vectors queued at capture and checked when outReady rises.
module tb_vector_sub_10_serial;

  localparam int W = 10;

  logic clk = 1'b0;
  logic reset, enable, inReady;
  logic signed [W:0]   s_in  [10];
  logic signed [W-1:0] b_in  [10];
  logic signed [W+1:0] d_out [10];
  logic outReady, earlyOutReady, busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  vector_sub_10_serial #(.IN_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
    .S0(s_in[0]), .S1(s_in[1]), .S2(s_in[2]), .S3(s_in[3]), .S4(s_in[4]),
    .S5(s_in[5]), .S6(s_in[6]), .S7(s_in[7]), .S8(s_in[8]), .S9(s_in[9]),
    .B0(b_in[0]), .B1(b_in[1]), .B2(b_in[2]), .B3(b_in[3]), .B4(b_in[4]),
    .B5(b_in[5]), .B6(b_in[6]), .B7(b_in[7]), .B8(b_in[8]), .B9(b_in[9]),
    .D0(d_out[0]), .D1(d_out[1]), .D2(d_out[2]), .D3(d_out[3]), .D4(d_out[4]),
    .D5(d_out[5]), .D6(d_out[6]), .D7(d_out[7]), .D8(d_out[8]), .D9(d_out[9]),
    .outReady(outReady), .earlyOutReady(earlyOutReady), .busy(busy)
  );

  typedef struct packed {
    logic [9:0][10:0] s;
    logic [9:0][9:0]  b;
    logic [9:0][11:0] d;
  } vec_t;

  vec_t tbl [5];
  vec_t sbq [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic set_elem(input int v, input int k, input int s, input int b);
    tbl[v].s[k] = 11'(s);
    tbl[v].b[k] = 10'(b);
    tbl[v].d[k] = 12'(s - b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    for (int k = 0; k < 10; k++) begin
      s_in[k] = v.s[k];
      b_in[k] = v.b[k];
    end
  endtask

  task automatic sb_check(input string tag);
    vec_t v;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      v = sbq.pop_front();
      for (int k = 0; k < 10; k++)
        check($sformatf("%s_D%0d", tag, k), int'(d_out[k]), int'($signed(v.d[k])));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_D%0d", tag, k), int'(d_out[k]), 0);
    check({tag, "_out"}, int'(outReady), 0);
    check({tag, "_early"}, int'(earlyOutReady), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // One isolated operation: 1-cycle inReady pulse, strobe timing and pulse widths checked.
  task automatic run_one(input vec_t v, input string tag);
    int e_at, o_at, n_e, n_o;
    e_at = -1; o_at = -1; n_e = 0; n_o = 0;
    drive(v);
    inReady = 1'b1;
    sbq.push_back(v);
    tick();
    inReady = 1'b0;
    check({tag, "_busy_run"}, int'(busy), 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (earlyOutReady) begin
        n_e++;
        if (e_at < 0) e_at = c;
      end
      if (outReady) begin
        n_o++;
        if (o_at < 0) begin
          o_at = c;
          sb_check(tag);
        end
      end
    end
    check({tag, "_early_at"}, e_at, 9);
    check({tag, "_out_at"}, o_at, 10);
    check({tag, "_early_width"}, n_e, 1);
    check({tag, "_out_width"}, n_o, 1);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n_o, o_at, t, last_out;

    reset = 1'b1; enable = 1'b1; inReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_in[k] = '0;
      b_in[k] = '0;
    end

    for (int k = 0; k < 10; k++) set_elem(0, k, 100 * k, k);
    for (int k = 0; k < 10; k++)
      set_elem(1, k, int'($urandom_range(2047, 0)) - 1024, int'($urandom_range(1023, 0)) - 512);
    set_elem(1, 0, 1023, -512);
    set_elem(1, 1, -1024, 511);
    set_elem(1, 2, 0, 0);
    for (int v = 2; v < 4; v++)
      for (int k = 0; k < 10; k++)
        set_elem(v, k, int'($urandom_range(2047, 0)) - 1024, int'($urandom_range(1023, 0)) - 512);
    for (int k = 0; k < 10; k++)
      set_elem(4, k, (k % 2 == 0) ? -1024 : 1023, (k % 2 == 0) ? 511 : -512);

    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 5; v++) run_one(tbl[v], $sformatf("vec%0d", v));

    // Second inReady while busy must be ignored.
    n_o = 0; o_at = -1;
    drive(tbl[2]);
    inReady = 1'b1;
    sbq.push_back(tbl[2]);
    tick();
    inReady = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        drive(tbl[3]);
        inReady = 1'b1;
      end
      tick();
      inReady = 1'b0;
      if (outReady) begin
        n_o++;
        if (o_at < 0) begin
          o_at = c;
          sb_check("busyrej");
        end
      end
    end
    check("busyrej_out_count", n_o, 1);
    check("busyrej_out_at", o_at, 10);
    check("busyrej_busy_idle", int'(busy), 0);

    // Stall at idx=5, then stall during DONE.
    drive(tbl[0]);
    inReady = 1'b1;
    sbq.push_back(tbl[0]);
    tick();
    inReady = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    enable = 1'b0;
    tick(); tick(); tick();
    check("stall_D4_new", int'(d_out[4]), int'($signed(tbl[0].d[4])));
    check("stall_D5_old", int'(d_out[5]), int'($signed(tbl[2].d[5])));
    check("stall_busy", int'(busy), 1);
    check("stall_out", int'(outReady), 0);
    enable = 1'b1;
    t = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (outReady) begin
        t = i;
        break;
      end
    end
    check("stall_resume_out_at", t, 5);
    if (t > 0) sb_check("stall");
    enable = 1'b0;
    tick(); tick();
    check("done_stall_out", int'(outReady), 1);
    check("done_stall_busy", int'(busy), 1);
    check("done_stall_early", int'(earlyOutReady), 0);
    enable = 1'b1;
    tick();
    check("done_resume_out", int'(outReady), 0);
    check("done_resume_busy", int'(busy), 0);

    // Reset at idx=4 abandons the operation; capture right after reset.
    drive(tbl[1]);
    inReady = 1'b1;
    sbq.push_back(tbl[1]);
    tick();
    inReady = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    sbq.delete();
    reset = 1'b0;
    run_one(tbl[3], "postrst");

    // inReady held high: captures every 12 cycles.
    last_out = -1;
    inReady = 1'b1;
    for (int r = 0; r < 3; r++) begin
      drive(tbl[2 + r]);
      sbq.push_back(tbl[2 + r]);
      tick();
      if (r == 2) inReady = 1'b0;
      check($sformatf("b2b%0d_busy", r), int'(busy), 1);
      n_o = 0;
      for (int c = 1; c <= 11; c++) begin
        tick();
        if (outReady) begin
          n_o++;
          check($sformatf("b2b%0d_out_at", r), c, 10);
          sb_check($sformatf("b2b%0d", r));
          if (last_out >= 0) check($sformatf("b2b%0d_spacing", r), cyc - last_out, 12);
          last_out = cyc;
        end
      end
      check($sformatf("b2b%0d_out_count", r), n_o, 1);
    end
    tick();
    check("final_busy", int'(busy), 0);
    check("final_sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
